// File: rtl/led_frame_scheduler_pkg.sv
// Shared definitions for the LED ring frame scheduler: FSM encoding,
// ring size and default timing parameters.
package led_frame_scheduler_pkg;

  localparam int N_LED             = 12;
  localparam int FRAME_MIN_CYC_DEF = 400000;  // 10 ms at 40 MHz
  localparam int ACK_TIMEOUT_DEF   = 8;

  // Mask shown after reset: LED 0 only
  localparam logic [N_LED-1:0] MASK_RESET = 12'h001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    KICK  = 3'd2,
    ACK   = 3'd3,
    DRAIN = 3'd4,
    HOLD  = 3'd5
  } state_t;

endpackage

// File: rtl/led_mask_gen.sv
// Combinational LED mask generator: dot mode lights LED pos only, bar mode
// lights LEDs 0..pos. Positions above N_LED-1 are filtered by the caller.
module led_mask_gen
  import led_frame_scheduler_pkg::*;
(
  input  logic [3:0]       pos,
  input  logic             mode,
  output logic [N_LED-1:0] mask
);

  logic [N_LED-1:0] one_hot;
  logic [N_LED-1:0] bar;

  // Bar is (2<<pos)-1; doing it modulo 2^N_LED gives the same truncated
  // result as the 13-bit form (pos=11 wraps to 0, minus 1 = all ones).
  always_comb begin
    one_hot = N_LED'(1) << pos;
    bar     = (one_hot << 1) - N_LED'(1);
    mask    = mode ? bar : one_hot;
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// LED frame scheduler: captures position/config updates into shadow
// registers and sends them to the LED ring driver as rate-limited frames.
//
// Handshake with the driver: drv_refresh is a one-cycle start pulse, only
// issued while drv_busy=0; the driver acknowledges by raising drv_busy
// within ACK_TIMEOUT cycles and lowering it when transmission is done.
// The drv_* data outputs are stable from the refresh pulse until busy drops.
module led_frame_scheduler
  import led_frame_scheduler_pkg::*;
#(
  parameter int FRAME_MIN_CYC = FRAME_MIN_CYC_DEF,
  parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        pos_valid,
  input  logic [3:0]  pos,
  input  logic        mode,
  input  logic        cfg_valid,
  input  logic [1:0]  cfg_colour,
  input  logic [7:0]  cfg_intensity,
  input  logic        drv_busy,
  output logic        drv_refresh,
  output logic [11:0] drv_led_mask,
  output logic [1:0]  drv_colour,
  output logic [7:0]  drv_intensity,
  output logic        pending,
  output logic        ack_err,
  output logic [2:0]  dbg_state
);

  localparam int FCW = (FRAME_MIN_CYC > 1) ? $clog2(FRAME_MIN_CYC) : 1;
  localparam int ACW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_MIN_CYC - 1);
  // ack_cnt is cleared as the pulse leaves KICK, so it reads k-1 in the
  // k-th cycle after the pulse; the error lands ACK_TIMEOUT cycles after it.
  localparam logic [ACW-1:0] ACK_LAST =
    ACW'((ACK_TIMEOUT >= 2) ? (ACK_TIMEOUT - 2) : 0);
  localparam logic [3:0] POS_MAX = 4'(N_LED - 1);

  state_t           state;
  state_t           next_state;
  logic [N_LED-1:0] gen_mask;
  logic [N_LED-1:0] shadow_mask;
  logic [1:0]       shadow_colour;
  logic [7:0]       shadow_intensity;
  logic [FCW-1:0]   frame_cnt;
  logic [ACW-1:0]   ack_cnt;
  logic             pos_accept;
  logic             capture;
  logic             set_ack_err;

  assign pos_accept = pos_valid && (pos <= POS_MAX);
  assign capture    = pos_accept || cfg_valid;
  assign dbg_state  = state;

  led_mask_gen u_mask_gen (
    .pos  (pos),
    .mode (mode),
    .mask (gen_mask)
  );

  // FSM state register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic, refresh pulse and timeout detection
  always_comb begin
    next_state  = state;
    drv_refresh = 1'b0;
    set_ack_err = 1'b0;
    case (state)
      IDLE:  if (pending && !drv_busy) next_state = LOAD;
      LOAD:  next_state = KICK;
      KICK: begin
        // Never start a frame on top of a busy driver; wait it out instead
        if (!drv_busy) begin
          drv_refresh = 1'b1;
          next_state  = ACK;
        end
      end
      ACK: begin
        if (drv_busy) begin
          next_state = DRAIN;
        end else if (ack_cnt >= ACK_LAST) begin
          set_ack_err = 1'b1;
          next_state  = HOLD;
        end
      end
      DRAIN: if (!drv_busy) next_state = HOLD;
      HOLD:  if (frame_cnt == FRAME_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shadow registers: latest accepted strobe wins, in any state
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shadow_mask      <= MASK_RESET;
      shadow_colour    <= '0;
      shadow_intensity <= '0;
    end else begin
      if (pos_accept) shadow_mask <= gen_mask;
      if (cfg_valid) begin
        shadow_colour    <= cfg_colour;
        shadow_intensity <= cfg_intensity;
      end
    end
  end

  // Pending flag: set by any capture, cleared by LOAD unless a capture coincides
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)               pending <= 1'b1;
    else if (capture)         pending <= 1'b1;
    else if (state == LOAD)   pending <= 1'b0;
  end

  // Driver-facing data only changes in LOAD
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      drv_led_mask  <= MASK_RESET;
      drv_colour    <= '0;
      drv_intensity <= '0;
    end else if (state == LOAD) begin
      drv_led_mask  <= shadow_mask;
      drv_colour    <= shadow_colour;
      drv_intensity <= shadow_intensity;
    end
  end

  // Frame counter: restarts at the refresh pulse, saturates at its last value
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                       frame_cnt <= '0;
    else if (drv_refresh)             frame_cnt <= '0;
    else if (frame_cnt != FRAME_LAST) frame_cnt <= frame_cnt + 1'b1;
  end

  // Ack counter: cleared in KICK, counts cycles spent waiting in ACK
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                                 ack_cnt <= '0;
    else if (state == KICK)                     ack_cnt <= '0;
    else if (state == ACK && ack_cnt < ACK_LAST) ack_cnt <= ack_cnt + 1'b1;
  end

  // Sticky acknowledge error, cleared only by reset
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)           ack_err <= 1'b0;
    else if (set_ack_err) ack_err <= 1'b1;
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Bench for led_frame_scheduler: directed scenarios plus randomized strobes,
// frames scored against a model of the shadow contents.
module tb_led_frame_scheduler;
  import led_frame_scheduler_pkg::*;

  localparam int F = 40;
  localparam int A = 6;
  localparam int W = 22;

  logic        clk;
  logic        res_n;
  logic        pos_valid;
  logic [3:0]  pos;
  logic        mode;
  logic        cfg_valid;
  logic [1:0]  cfg_colour;
  logic [7:0]  cfg_intensity;
  logic        drv_busy = 1'b0;
  logic        drv_refresh;
  logic [11:0] drv_led_mask;
  logic [1:0]  drv_colour;
  logic [7:0]  drv_intensity;
  logic        pending;
  logic        ack_err;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_cnt = 0;
  int ref_cyc = 0;
  int last_ref_epoch = -1;
  int epoch = 0;
  logic [W-1:0] exp_q[$];
  int model_mask;
  int model_colour;
  int model_int;
  bit drv_model_en = 1'b1;
  int busy_dly = 0;
  int busy_len = 0;

  led_frame_scheduler #(.FRAME_MIN_CYC(F), .ACK_TIMEOUT(A)) dut (
    .clk           (clk),
    .res_n         (res_n),
    .pos_valid     (pos_valid),
    .pos           (pos),
    .mode          (mode),
    .cfg_valid     (cfg_valid),
    .cfg_colour    (cfg_colour),
    .cfg_intensity (cfg_intensity),
    .drv_busy      (drv_busy),
    .drv_refresh   (drv_refresh),
    .drv_led_mask  (drv_led_mask),
    .drv_colour    (drv_colour),
    .drv_intensity (drv_intensity),
    .pending       (pending),
    .ack_err       (ack_err),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LEDs lit for a position, from the plain meaning of dot and bar
  function automatic int ref_mask(input int p, input bit bar);
    int m = 0;
    for (int i = 0; i < N_LED; i++)
      if ((bar && i <= p) || (!bar && i == p)) m = m | (1 << i);
    return m;
  endfunction

  // Scoreboard on every refresh pulse, then the LED driver model
  always @(negedge clk) begin
    if (drv_refresh === 1'b1) begin
      check("refresh_while_busy", drv_busy, 0);
      if (last_ref_epoch == epoch)
        check("refresh_spacing", (cyc - ref_cyc) >= F, 1);
      check("refresh_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("frame_content", {drv_led_mask, drv_colour, drv_intensity}, exp_q.pop_front());
      ref_cyc        = cyc;
      last_ref_epoch = epoch;
      ref_cnt++;
    end
    if (!res_n || !drv_model_en) begin
      drv_busy = 1'b0;
      busy_dly = 0;
      busy_len = 0;
    end else begin
      if (busy_dly > 0) begin
        busy_dly--;
        if (busy_dly == 0) begin
          drv_busy = 1'b1;
          busy_len = $urandom_range(2, 10);
        end
      end else if (busy_len > 0) begin
        busy_len--;
        if (busy_len == 0) drv_busy = 1'b0;
      end
      if (drv_refresh === 1'b1) busy_dly = $urandom_range(1, 3);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input bit pv, input int p, input bit m,
                        input bit cv, input int col, input int inten);
    pos_valid     = pv;
    pos           = 4'(p);
    mode          = m;
    cfg_valid     = cv;
    cfg_colour    = 2'(col);
    cfg_intensity = 8'(inten);
    if (pv && p <= N_LED - 1) model_mask = ref_mask(p, m);
    if (cv) begin
      model_colour = col;
      model_int    = inten;
    end
    step();
    pos_valid = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic expect_frame();
    exp_q.push_back({12'(model_mask), 2'(model_colour), 8'(model_int)});
  endtask

  task automatic model_reset();
    model_mask   = 1;
    model_colour = 0;
    model_int    = 0;
  endtask

  task automatic wait_refs(input int target, input int budget, input string tag);
    int n = 0;
    while (ref_cnt < target && n < budget) begin
      step();
      n++;
    end
    check(tag, ref_cnt >= target, 1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_refresh"}, drv_refresh, 0);
    check({pfx, "_mask"}, drv_led_mask, 12'h001);
    check({pfx, "_colour"}, drv_colour, 0);
    check({pfx, "_intensity"}, drv_intensity, 0);
    check({pfx, "_pending"}, pending, 1);
    check({pfx, "_ack_err"}, ack_err, 0);
    check({pfx, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rel;
    int prev;
    int n;
    res_n = 1'b1;
    pos_valid = 1'b0; pos = '0; mode = 1'b0;
    cfg_valid = 1'b0; cfg_colour = '0; cfg_intensity = '0;
    model_reset();
    #1 res_n = 1'b0;
    repeat (3) step();
    check_reset_values("rst");

    // First frame after reset: LED 0, zero intensity, within 3 cycles
    expect_frame();
    rel = cyc;
    res_n = 1'b1;
    wait_refs(1, 10, "first_refresh_timeout");
    check("first_refresh_latency", (ref_cyc - rel) <= 3, 1);
    check("pending_cleared", pending, 0);

    // Dot then bar at position 5
    strobe(1, 5, 0, 0, 0, 0);
    expect_frame();
    wait_refs(2, 3 * F, "dot5_timeout");
    check("dot5_mask", drv_led_mask, 12'h020);
    repeat (5) step();
    strobe(1, 5, 1, 0, 0, 0);
    expect_frame();
    wait_refs(3, 3 * F, "bar5_timeout");
    check("bar5_mask", drv_led_mask, 12'h03F);

    // Out-of-range position is ignored entirely
    repeat (F + 10) step();
    n = ref_cnt;
    strobe(1, 12, 0, 0, 0, 0);
    step();
    check("pos12_pending", pending, 0);
    repeat (F) step();
    check("pos12_no_refresh", ref_cnt, n);
    check("pos12_mask_kept", drv_led_mask, 12'h03F);

    // Burst during DRAIN/HOLD collapses into one frame with the last value
    strobe(1, 0, 1, 0, 0, 0);
    expect_frame();
    wait_refs(n + 1, 3 * F, "burst_lead_timeout");
    prev = ref_cyc;
    repeat (5) step();
    strobe(1, 1, 0, 0, 0, 0);
    repeat (3) step();
    strobe(1, 2, 0, 0, 0, 0);
    repeat (3) step();
    strobe(1, 3, 0, 0, 0, 0);
    expect_frame();
    wait_refs(n + 2, 3 * F, "burst_timeout");
    check("burst_mask", drv_led_mask, 12'h008);
    check("burst_spacing", (ref_cyc - prev) >= F, 1);
    repeat (F + 10) step();
    check("burst_single_frame", ref_cnt, n + 2);

    // Position and config in the same cycle form one frame
    strobe(1, 11, 0, 1, 1, 'h80);
    expect_frame();
    wait_refs(n + 3, 3 * F, "combo_timeout");
    check("combo_mask", drv_led_mask, 12'h800);
    check("combo_colour", drv_colour, 2'b01);
    check("combo_intensity", drv_intensity, 8'h80);
    check("combo_no_ack_err", ack_err, 0);

    // Driver never acknowledges: sticky error after ACK_TIMEOUT cycles
    repeat (F + 10) step();
    drv_model_en = 1'b0;
    strobe(1, 7, 0, 0, 0, 0);
    expect_frame();
    wait_refs(n + 4, 3 * F, "noack_timeout");
    prev = ref_cyc;
    repeat (A - 1) step();
    check("ack_err_early", ack_err, 0);
    step();
    check("ack_err_set", ack_err, 1);
    check("ack_err_hold", dbg_state, HOLD);
    check("ack_err_cycle", cyc - prev, A);
    strobe(1, 2, 1, 0, 0, 0);
    expect_frame();
    wait_refs(n + 5, 3 * F, "after_err_timeout");
    check("after_err_mask", drv_led_mask, 12'h007);
    check("ack_err_sticky", ack_err, 1);
    repeat (F + 10) step();
    drv_model_en = 1'b1;

    // Randomized strobes, one frame per accepted strobe
    for (int i = 0; i < 12; i++) begin
      int p, col, inten;
      bit m, cv;
      repeat ($urandom_range(0, F + 20)) step();
      p     = $urandom_range(0, 13);
      m     = 1'($urandom_range(0, 1));
      cv    = ($urandom_range(0, 2) == 0);
      col   = $urandom_range(0, 3);
      inten = $urandom_range(0, 255);
      strobe(1, p, m, cv, col, inten);
      if (p <= N_LED - 1 || cv) begin
        n = ref_cnt + 1;
        expect_frame();
        wait_refs(n, 3 * F, "rand_timeout");
      end else begin
        repeat (3) step();
        check("rand_ignored_pending", pending, 0);
      end
    end

    // Reset mid-frame aborts and restarts with the reset frame
    repeat (F + 10) step();
    strobe(1, 9, 0, 1, 3, 'hFF);
    expect_frame();
    n = ref_cnt + 1;
    wait_refs(n, 3 * F, "pre_reset_timeout");
    repeat (4) step();
    res_n = 1'b0;
    epoch++;
    model_reset();
    step();
    check_reset_values("midrst");
    repeat (3) step();
    expect_frame();
    rel = cyc;
    res_n = 1'b1;
    wait_refs(n + 1, 10, "post_reset_timeout");
    check("post_reset_latency", (ref_cyc - rel) <= 3, 1);

    repeat (F + 10) step();
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_scheduler.md
LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 Parameter FRAME_MIN_CYC, default 400000, is the minimum number of clk cycles between consecutive refresh pulses (10 ms at 40 MHz).
REQ-002 Parameter ACK_TIMEOUT, default 8, is the number of cycles allowed for drv_busy to rise after refresh.
REQ-003 Port clk, input, 1 bit: 40 MHz clock, rising edge.
REQ-004 Port res_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port pos_valid, input, 1 bit: one-cycle strobe qualifying pos and mode.
REQ-006 Port pos, input, 4 bits: encoder position, valid range 0..11.
REQ-007 Port mode, input, 1 bit: 0 = dot (one-hot), 1 = bar (bits 0..pos set).
REQ-008 Port cfg_valid, input, 1 bit: one-cycle strobe qualifying cfg_colour and cfg_intensity.
REQ-009 Port cfg_colour, input, 2 bits: colour select passed to the driver.
REQ-010 Port cfg_intensity, input, 8 bits: intensity passed to the driver.
REQ-011 Port drv_busy, input, 1 bit: busy flag from the LED ring driver.
REQ-012 Port drv_refresh, output, 1 bit: one-cycle transmission start pulse to the driver.
REQ-013 Port drv_led_mask, output, 12 bits: LED mask to the driver.
REQ-014 Port drv_colour, output, 2 bits: colour to the driver.
REQ-015 Port drv_intensity, output, 8 bits: intensity to the driver.
REQ-016 Port pending, output, 1 bit: an update is captured but not yet sent.
REQ-017 Port ack_err, output, 1 bit: sticky flag; the driver failed to assert busy within ACK_TIMEOUT.

Function
REQ-018 When pos_valid=1 and pos<=11, the shadow mask SHALL load: dot = 1<<pos; bar = (2<<pos)-1, computed 13 bits wide and truncated to 12.
REQ-019 When pos_valid=1 and pos>11, the strobe SHALL be ignored, with no shadow change and no pending change.
REQ-020 When cfg_valid=1, shadow colour and shadow intensity SHALL load.
REQ-021 Any accepted strobe SHALL set pending one cycle later; the latest value wins; pos and cfg strobes in the same cycle SHALL both be captured into a single frame.
REQ-022 FSM state IDLE: if pending=1 and drv_busy=0, go to LOAD.
REQ-023 FSM state LOAD: copy shadow registers to the drv_* outputs, clear pending, go to KICK.
REQ-024 FSM state KICK: drive drv_refresh=1 for exactly one cycle, clear the ack counter, go to ACK.
REQ-025 FSM state ACK: on drv_busy=1 go to DRAIN; after ACK_TIMEOUT cycles without busy, set ack_err and go to HOLD.
REQ-026 FSM state DRAIN: wait for drv_busy=0, then go to HOLD.
REQ-027 FSM state HOLD: go to IDLE when the frame counter, started at KICK, reaches FRAME_MIN_CYC-1.
REQ-028 The frame counter SHALL be clog2(FRAME_MIN_CYC) bits wide and saturate, never wrap.
REQ-029 drv_led_mask, drv_colour and drv_intensity SHALL change only in LOAD, and SHALL be stable from KICK through DRAIN.
REQ-030 A strobe arriving in any state other than IDLE SHALL update the shadow registers only; a capture in the same cycle as LOAD SHALL re-set pending.
REQ-031 drv_refresh SHALL never be asserted while drv_busy=1.
REQ-032 The refresh-to-refresh distance SHALL be at least FRAME_MIN_CYC cycles.

Reset
REQ-033 While res_n=0, the following SHALL be asynchronously forced: state=IDLE, drv_refresh=0, drv_led_mask=12'h001, drv_colour=0, drv_intensity=0, pending=1, ack_err=0, counters=0.
REQ-034 The shadow registers SHALL reset to mask 12'h001, colour 0 and intensity 0, so the first frame after reset shows LED 0 at zero intensity.
REQ-035 Reset asserted mid-frame SHALL abort immediately, with no refresh pulse generated during reset.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding (IDLE, LOAD, KICK, ACK, DRAIN, HOLD; 3 bits), N_LED=12, and the defaults for FRAME_MIN_CYC and ACK_TIMEOUT.
REQ-037 Mask generation SHALL be the single sub-module led_mask_gen (pos, mode -> 12-bit mask), purely combinational; all sequencing SHALL stay in the top module.

Verification
REQ-038 Scenario: release reset, drv_busy low -> one drv_refresh with mask 12'h001, colour 0 and intensity 0 within 3 cycles.
REQ-039 Scenario: pos_valid with pos=5 and mode=0, then pos_valid with pos=5 and mode=1 after the frame -> masks 12'h020 and 12'h03F.
REQ-040 Scenario: pos_valid with pos=12 -> no shadow change, pending stays 0, no refresh.
REQ-041 Scenario: three pos strobes (pos 1, 2, 3) during DRAIN/HOLD -> exactly one further refresh, mask 12'h008, no earlier than FRAME_MIN_CYC cycles after the previous refresh.
REQ-042 Scenario: pos_valid and cfg_valid in the same cycle (pos=11, colour 2'b01, intensity 8'h80) -> one refresh with mask 12'h800, colour 2'b01 and intensity 8'h80.
REQ-043 Scenario: drv_busy tied low after refresh -> ack_err=1 at cycle KICK+ACK_TIMEOUT, FSM passes through HOLD, and the next pending frame is still sent.
